// File: rtl/toy_alu_issue_queue.sv
// ---------------------------------------------------------------------------
// toy_alu_issue_queue
//
// Data-capture issue queue in front of the single-cycle ALU. Holds renamed
// ALU/branch instructions until both sources are available, captures source
// values from write-back broadcasts, and issues the oldest ready entry.
//
// Optional build macro: TOY_ALU_IQ_PERF_EN adds two 32-bit perf counters.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   disp_valid / disp_ready     dispatch handshake (one entry per cycle)
//   disp_pld                    instruction payload (src values valid if rdy)
//   disp_rs1/2_idx, _rdy        physical sources and their readiness
//   wb_en/wb_index/wb_data      WB_NUM write-back wakeup broadcast ports
//   flush                       mispredict flush, highest priority
//   issue_en / issue_pld        registered issue to the ALU
//   iq_empty                    registered "no valid entries"
//   perf_full_cycles            (macro only) cycles with disp_ready low
//   perf_issue_cnt              (macro only) number of issue_en cycles
// ---------------------------------------------------------------------------
package eu_pkg;
    localparam int REG_WIDTH        = 32;
    localparam int PHY_REG_ID_WIDTH = 6;

    typedef struct packed {
        logic [3:0]                  alu_op;
        logic [PHY_REG_ID_WIDTH-1:0] rd_idx;
        logic [31:0]                 pc;
        logic [31:0]                 imm;
        logic [REG_WIDTH-1:0]        reg_rs1_val;
        logic [REG_WIDTH-1:0]        reg_rs2_val;
    } instruction_pld_t;
endpackage

module toy_alu_issue_queue
    import eu_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int WB_NUM    = 2,
    parameter int PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     disp_valid,
    output logic                                     disp_ready,
    input  instruction_pld_t                         disp_pld,
    input  logic [PHY_REG_ID_WIDTH-1:0]              disp_rs1_idx,
    input  logic [PHY_REG_ID_WIDTH-1:0]              disp_rs2_idx,
    input  logic                                     disp_rs1_rdy,
    input  logic                                     disp_rs2_rdy,
    input  logic [WB_NUM-1:0]                        wb_en,
    input  logic [WB_NUM-1:0][PHY_REG_ID_WIDTH-1:0]  wb_index,
    input  logic [WB_NUM-1:0][REG_WIDTH-1:0]         wb_data,
    input  logic                                     flush,
    output logic                                     issue_en,
    output instruction_pld_t                         issue_pld,
    output logic                                     iq_empty
`ifdef TOY_ALU_IQ_PERF_EN
    ,
    output logic [31:0]                              perf_full_cycles,
    output logic [31:0]                              perf_issue_cnt
`endif
);

    logic [DEPTH-1:0]     w_valid, w_ready, w_sel, w_alloc_oh, w_valid_next;
    logic [DEPTH-1:0]     w_age [DEPTH];   // w_age[j][i]: entry j older than i
    instruction_pld_t     w_pld [DEPTH];
    logic [PTR_WIDTH-1:0] w_sel_idx, w_alloc_idx;
    logic                 w_any_ready, w_disp_fire, w_bypass_issue, w_alloc, w_issue;
    logic                 w_disp_rs1_hit, w_disp_rs2_hit;
    logic [REG_WIDTH-1:0] w_disp_rs1_wb, w_disp_rs2_wb;
    logic                 w_new_rs1_rdy, w_new_rs2_rdy;
    instruction_pld_t     w_new_pld, w_issue_pld;

    logic                 r_issue_en, r_iq_empty;
    instruction_pld_t     r_issue_pld;

    // Full is judged on registered valid bits only; an entry issued this
    // cycle frees its slot for dispatch one cycle later.
    assign disp_ready  = ~rst & ~(&w_valid);
    assign w_disp_fire = disp_valid & disp_ready;

    // Same-cycle wakeup of the dispatching instruction. Descending loop so
    // the lowest matching port is the last assignment and wins.
    always_comb begin
        w_disp_rs1_hit = 1'b0;
        w_disp_rs1_wb  = '0;
        w_disp_rs2_hit = 1'b0;
        w_disp_rs2_wb  = '0;
        for (int k = WB_NUM - 1; k >= 0; k--) begin
            if (wb_en[k] && (wb_index[k] == disp_rs1_idx)) begin
                w_disp_rs1_hit = 1'b1;
                w_disp_rs1_wb  = wb_data[k];
            end
            if (wb_en[k] && (wb_index[k] == disp_rs2_idx)) begin
                w_disp_rs2_hit = 1'b1;
                w_disp_rs2_wb  = wb_data[k];
            end
        end
    end

    assign w_new_rs1_rdy = disp_rs1_rdy | w_disp_rs1_hit;
    assign w_new_rs2_rdy = disp_rs2_rdy | w_disp_rs2_hit;

    always_comb begin
        w_new_pld = disp_pld;
        if (!disp_rs1_rdy && w_disp_rs1_hit) w_new_pld.reg_rs1_val = w_disp_rs1_wb;
        if (!disp_rs2_rdy && w_disp_rs2_hit) w_new_pld.reg_rs2_val = w_disp_rs2_wb;
    end

    // Oldest-ready select: an entry wins if no other ready entry is older.
    always_comb begin
        w_sel = w_ready;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if ((j != i) && w_ready[j] && w_age[j][i]) w_sel[i] = 1'b0;
            end
        end
    end

    always_comb begin
        w_sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_sel[i]) w_sel_idx = PTR_WIDTH'(i);
        end
    end

    // Lowest-index free entry (descending loop, last hit wins).
    always_comb begin
        w_alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!w_valid[i]) w_alloc_idx = PTR_WIDTH'(i);
        end
    end

    assign w_any_ready = |w_ready;

    // A fully-ready dispatch is the youngest candidate, so it may go
    // straight to the issue register only when nothing queued is ready.
    // It then never occupies an entry.
    assign w_bypass_issue = w_disp_fire & w_new_rs1_rdy & w_new_rs2_rdy & ~w_any_ready;
    assign w_alloc        = w_disp_fire & ~w_bypass_issue;
    assign w_issue        = w_any_ready | w_bypass_issue;
    assign w_issue_pld    = w_bypass_issue ? w_new_pld : w_pld[w_sel_idx];
    assign w_alloc_oh     = w_alloc ? (DEPTH'(1) << w_alloc_idx) : '0;
    assign w_valid_next   = (w_valid & ~w_sel) | w_alloc_oh;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic                        r_valid, r_rs1_rdy, r_rs2_rdy;
            logic [PHY_REG_ID_WIDTH-1:0] r_rs1_idx, r_rs2_idx;
            instruction_pld_t            r_pld;
            logic [DEPTH-1:0]            r_age_row;
            logic                        w_rs1_hit, w_rs2_hit, w_alloc_me;
            logic [REG_WIDTH-1:0]        w_rs1_wb, w_rs2_wb;

            always_comb begin
                w_rs1_hit = 1'b0;
                w_rs1_wb  = '0;
                w_rs2_hit = 1'b0;
                w_rs2_wb  = '0;
                for (int k = WB_NUM - 1; k >= 0; k--) begin
                    if (wb_en[k] && (wb_index[k] == r_rs1_idx)) begin
                        w_rs1_hit = 1'b1;
                        w_rs1_wb  = wb_data[k];
                    end
                    if (wb_en[k] && (wb_index[k] == r_rs2_idx)) begin
                        w_rs2_hit = 1'b1;
                        w_rs2_wb  = wb_data[k];
                    end
                end
            end

            assign w_alloc_me  = w_alloc && (w_alloc_idx == PTR_WIDTH'(gi));
            assign w_valid[gi] = r_valid;
            assign w_ready[gi] = r_valid & r_rs1_rdy & r_rs2_rdy;
            assign w_age[gi]   = r_age_row;
            assign w_pld[gi]   = r_pld;

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    r_valid   <= 1'b0;
                    r_age_row <= '0;
                end else if (w_alloc_me) begin
                    r_valid   <= 1'b1;
                    r_rs1_rdy <= w_new_rs1_rdy;
                    r_rs2_rdy <= w_new_rs2_rdy;
                    r_rs1_idx <= disp_rs1_idx;
                    r_rs2_idx <= disp_rs2_idx;
                    r_pld     <= w_new_pld;
                    // Newcomer is older than nobody.
                    r_age_row <= '0;
                end else begin
                    if (w_sel[gi]) r_valid <= 1'b0;
                    if (r_valid && !r_rs1_rdy && w_rs1_hit) begin
                        r_rs1_rdy         <= 1'b1;
                        r_pld.reg_rs1_val <= w_rs1_wb;
                    end
                    if (r_valid && !r_rs2_rdy && w_rs2_hit) begin
                        r_rs2_rdy         <= 1'b1;
                        r_pld.reg_rs2_val <= w_rs2_wb;
                    end
                    // Every currently valid entry is older than the newcomer.
                    // Stale bits of invalid entries are masked by w_ready.
                    if (w_alloc) r_age_row[w_alloc_idx] <= r_valid;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_en  <= 1'b0;
            r_issue_pld <= '0;
            r_iq_empty  <= 1'b1;
        end else if (flush) begin
            r_issue_en  <= 1'b0;
            r_iq_empty  <= 1'b1;
        end else begin
            r_issue_en  <= w_issue;
            if (w_issue) r_issue_pld <= w_issue_pld;
            r_iq_empty  <= ~(|w_valid_next);
        end
    end

    assign issue_en  = r_issue_en;
    assign issue_pld = r_issue_pld;
    assign iq_empty  = r_iq_empty;

`ifdef TOY_ALU_IQ_PERF_EN
    logic [31:0] r_perf_full_cycles, r_perf_issue_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_full_cycles <= '0;
            r_perf_issue_cnt   <= '0;
        end else begin
            if (!disp_ready) r_perf_full_cycles <= r_perf_full_cycles + 32'd1;
            if (r_issue_en)  r_perf_issue_cnt   <= r_perf_issue_cnt + 32'd1;
        end
    end

    assign perf_full_cycles = r_perf_full_cycles;
    assign perf_issue_cnt   = r_perf_issue_cnt;
`endif

endmodule

// File: tb/tb_toy_alu_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_toy_alu_issue_queue
//
// Directed self-checking bench for toy_alu_issue_queue (default build).
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_toy_alu_issue_queue;
    import eu_pkg::*;

    logic                                clk = 1'b0;
    logic                                rst;
    logic                                disp_valid;
    logic                                disp_ready;
    instruction_pld_t                    disp_pld;
    logic [PHY_REG_ID_WIDTH-1:0]         disp_rs1_idx, disp_rs2_idx;
    logic                                disp_rs1_rdy, disp_rs2_rdy;
    logic [1:0]                          wb_en;
    logic [1:0][PHY_REG_ID_WIDTH-1:0]    wb_index;
    logic [1:0][REG_WIDTH-1:0]           wb_data;
    logic                                flush;
    logic                                issue_en;
    instruction_pld_t                    issue_pld;
    logic                                iq_empty;

    int n_checks = 0;
    int n_fail   = 0;

    toy_alu_issue_queue #(.DEPTH(8), .WB_NUM(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .disp_valid   (disp_valid),
        .disp_ready   (disp_ready),
        .disp_pld     (disp_pld),
        .disp_rs1_idx (disp_rs1_idx),
        .disp_rs2_idx (disp_rs2_idx),
        .disp_rs1_rdy (disp_rs1_rdy),
        .disp_rs2_rdy (disp_rs2_rdy),
        .wb_en        (wb_en),
        .wb_index     (wb_index),
        .wb_data      (wb_data),
        .flush        (flush),
        .issue_en     (issue_en),
        .issue_pld    (issue_pld),
        .iq_empty     (iq_empty)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        wb_en      = '0;
        flush      = 1'b0;
    endtask

    task automatic dispatch(input logic [31:0] pc,
                            input logic r1, input logic [5:0] i1, input logic [31:0] v1,
                            input logic r2, input logic [5:0] i2, input logic [31:0] v2);
        disp_valid              = 1'b1;
        disp_pld                = '0;
        disp_pld.alu_op         = 4'h1;
        disp_pld.rd_idx         = 6'd63;
        disp_pld.pc             = pc;
        disp_pld.reg_rs1_val    = v1;
        disp_pld.reg_rs2_val    = v2;
        disp_rs1_rdy            = r1;
        disp_rs2_rdy            = r2;
        disp_rs1_idx            = i1;
        disp_rs2_idx            = i2;
        $display("dispatch pc=%h rs1(rdy=%0b idx=%0d) rs2(rdy=%0b idx=%0d) ready=%0b",
                 pc, r1, i1, r2, i2, disp_ready);
    endtask

    task automatic set_wb(input int port, input logic [5:0] idx, input logic [31:0] data);
        wb_en[port]    = 1'b1;
        wb_index[port] = idx;
        wb_data[port]  = data;
        $display("writeback port=%0d idx=%0d data=%h", port, idx, data);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        step();
        step();
        n_checks++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL reset_disp_ready got=%0b exp=0", disp_ready); end
        n_checks++; if (issue_en !== 1'b0) begin n_fail++; $display("FAIL reset_issue_en got=%0b exp=0", issue_en); end
        n_checks++; if (iq_empty !== 1'b1) begin n_fail++; $display("FAIL reset_iq_empty got=%0b exp=1", iq_empty); end
        n_checks++; if (issue_pld !== '0) begin n_fail++; $display("FAIL reset_issue_pld got=%h exp=0", issue_pld); end
        rst = 1'b0;
        #1;
        n_checks++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_disp_ready got=%0b exp=1", disp_ready); end
        @(negedge clk);
    endtask

    task automatic test_basic_issue();
        dispatch(32'h100, 1'b1, 6'd1, 32'd5, 1'b1, 6'd2, 32'd7);
        step();
        idle();
        $display("issue en=%0b pc=%h rs1=%h rs2=%h", issue_en, issue_pld.pc, issue_pld.reg_rs1_val, issue_pld.reg_rs2_val);
        n_checks++; if (issue_en !== 1'b1) begin n_fail++; $display("FAIL basic_en got=%0b exp=1", issue_en); end
        n_checks++; if (issue_pld.pc !== 32'h100) begin n_fail++; $display("FAIL basic_pc got=%h exp=100", issue_pld.pc); end
        n_checks++; if (issue_pld.reg_rs1_val !== 32'd5) begin n_fail++; $display("FAIL basic_rs1 got=%h exp=5", issue_pld.reg_rs1_val); end
        n_checks++; if (issue_pld.reg_rs2_val !== 32'd7) begin n_fail++; $display("FAIL basic_rs2 got=%h exp=7", issue_pld.reg_rs2_val); end
        n_checks++; if (issue_pld.alu_op !== 4'h1) begin n_fail++; $display("FAIL basic_op got=%h exp=1", issue_pld.alu_op); end
        step();
        n_checks++; if (issue_en !== 1'b0) begin n_fail++; $display("FAIL basic_en_drop got=%0b exp=0", issue_en); end
        n_checks++; if (iq_empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty got=%0b exp=1", iq_empty); end
        n_checks++; if (issue_pld.pc !== 32'h100) begin n_fail++; $display("FAIL basic_hold_pc got=%h exp=100", issue_pld.pc); end
    endtask

    task automatic test_wakeup_order();
        dispatch(32'hA, 1'b0, 6'd12, 32'hBAD, 1'b1, 6'd13, 32'd2);
        step();
        n_checks++; if (issue_en !== 1'b0) begin n_fail++; $display("FAIL wake_a_early got=%0b exp=0", issue_en); end
        n_checks++; if (iq_empty !== 1'b0) begin n_fail++; $display("FAIL wake_nonempty got=%0b exp=0", iq_empty); end
        dispatch(32'hB, 1'b1, 6'd14, 32'd1, 1'b1, 6'd15, 32'd1);
        set_wb(0, 6'd12, 32'hDEAD);
        step();
        idle();
        $display("issue en=%0b pc=%h", issue_en, issue_pld.pc);
        n_checks++; if (issue_en !== 1'b1) begin n_fail++; $display("FAIL wake_b_en got=%0b exp=1", issue_en); end
        n_checks++; if (issue_pld.pc !== 32'hB) begin n_fail++; $display("FAIL wake_b_pc got=%h exp=b", issue_pld.pc); end
        step();
        $display("issue en=%0b pc=%h rs1=%h", issue_en, issue_pld.pc, issue_pld.reg_rs1_val);
        n_checks++; if (issue_en !== 1'b1) begin n_fail++; $display("FAIL wake_a_en got=%0b exp=1", issue_en); end
        n_checks++; if (issue_pld.pc !== 32'hA) begin n_fail++; $display("FAIL wake_a_pc got=%h exp=a", issue_pld.pc); end
        n_checks++; if (issue_pld.reg_rs1_val !== 32'hDEAD) begin n_fail++; $display("FAIL wake_a_rs1 got=%h exp=dead", issue_pld.reg_rs1_val); end
        n_checks++; if (issue_pld.reg_rs2_val !== 32'd2) begin n_fail++; $display("FAIL wake_a_rs2 got=%h exp=2", issue_pld.reg_rs2_val); end
        n_checks++; if (iq_empty !== 1'b1) begin n_fail++; $display("FAIL wake_empty got=%0b exp=1", iq_empty); end
        step();
        n_checks++; if (issue_en !== 1'b0) begin n_fail++; $display("FAIL wake_idle got=%0b exp=0", issue_en); end
    endtask

    task automatic test_dispatch_bypass();
        dispatch(32'hC, 1'b1, 6'd16, 32'd9, 1'b0, 6'd20, 32'hBAD);
        wb_index[0] = 6'd20;
        wb_data[0]  = 32'h99;
        set_wb(1, 6'd20, 32'h33);
        step();
        idle();
        $display("issue en=%0b pc=%h rs2=%h", issue_en, issue_pld.pc, issue_pld.reg_rs2_val);
        n_checks++; if (issue_en !== 1'b1) begin n_fail++; $display("FAIL bypass_en got=%0b exp=1", issue_en); end
        n_checks++; if (issue_pld.reg_rs2_val !== 32'h33) begin n_fail++; $display("FAIL bypass_rs2 got=%h exp=33", issue_pld.reg_rs2_val); end
        n_checks++; if (issue_pld.reg_rs1_val !== 32'd9) begin n_fail++; $display("FAIL bypass_rs1 got=%h exp=9", issue_pld.reg_rs1_val); end
        // Both ports hit the same source: port 0 must win.
        dispatch(32'hD, 1'b0, 6'd21, 32'hBAD, 1'b1, 6'd22, 32'd4);
        set_wb(0, 6'd21, 32'h44);
        set_wb(1, 6'd21, 32'h55);
        step();
        idle();
        $display("issue en=%0b pc=%h rs1=%h", issue_en, issue_pld.pc, issue_pld.reg_rs1_val);
        n_checks++; if (issue_en !== 1'b1) begin n_fail++; $display("FAIL port_prio_en got=%0b exp=1", issue_en); end
        n_checks++; if (issue_pld.reg_rs1_val !== 32'h44) begin n_fail++; $display("FAIL port_prio_rs1 got=%h exp=44", issue_pld.reg_rs1_val); end
        step();
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_%0d got=%0b exp=1", i, disp_ready); end
            dispatch(32'h10 + 32'(i), 1'b0, 6'(30 + i), 32'hBAD, 1'b1, 6'd1, 32'(i));
            step();
        end
        idle();
        n_checks++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%0b exp=0", disp_ready); end
        n_checks++; if (iq_empty !== 1'b0) begin n_fail++; $display("FAIL full_empty got=%0b exp=0", iq_empty); end
        dispatch(32'h99, 1'b1, 6'd2, 32'd1, 1'b1, 6'd3, 32'd1);
        step();
        idle();
        n_checks++; if (issue_en !== 1'b0) begin n_fail++; $display("FAIL full_drop_en got=%0b exp=0", issue_en); end
        n_checks++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL full_drop_ready got=%0b exp=0", disp_ready); end
        set_wb(0, 6'd33, 32'h1234);
        step();
        idle();
        n_checks++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL full_sel_ready got=%0b exp=0", disp_ready); end
        n_checks++; if (issue_en !== 1'b0) begin n_fail++; $display("FAIL full_sel_en got=%0b exp=0", issue_en); end
        step();
        $display("issue en=%0b pc=%h rs1=%h ready=%0b", issue_en, issue_pld.pc, issue_pld.reg_rs1_val, disp_ready);
        n_checks++; if (issue_en !== 1'b1) begin n_fail++; $display("FAIL full_issue_en got=%0b exp=1", issue_en); end
        n_checks++; if (issue_pld.pc !== 32'h13) begin n_fail++; $display("FAIL full_issue_pc got=%h exp=13", issue_pld.pc); end
        n_checks++; if (issue_pld.reg_rs1_val !== 32'h1234) begin n_fail++; $display("FAIL full_issue_rs1 got=%h exp=1234", issue_pld.reg_rs1_val); end
        n_checks++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL full_freed_ready got=%0b exp=1", disp_ready); end
        flush = 1'b1;
        step();
        idle();
    endtask

    task automatic test_age_order();
        dispatch(32'hE0, 1'b0, 6'd40, 32'hBAD, 1'b1, 6'd1, 32'd0);
        step();
        dispatch(32'hE1, 1'b0, 6'd41, 32'hBAD, 1'b1, 6'd1, 32'd0);
        step();
        dispatch(32'hE2, 1'b0, 6'd42, 32'hBAD, 1'b1, 6'd1, 32'd0);
        step();
        idle();
        set_wb(0, 6'd40, 32'h40);
        step();
        idle();
        step();
        n_checks++; if (issue_pld.pc !== 32'hE0 || issue_en !== 1'b1) begin n_fail++; $display("FAIL age_e0 got=%0b/%h exp=1/e0", issue_en, issue_pld.pc); end
        // Reuses entry 0 but is the youngest in the queue.
        dispatch(32'hE3, 1'b0, 6'd43, 32'hBAD, 1'b1, 6'd1, 32'd0);
        step();
        idle();
        set_wb(0, 6'd43, 32'h43);
        set_wb(1, 6'd42, 32'h42);
        step();
        idle();
        step();
        $display("issue en=%0b pc=%h rs1=%h", issue_en, issue_pld.pc, issue_pld.reg_rs1_val);
        n_checks++; if (issue_en !== 1'b1) begin n_fail++; $display("FAIL age_first_en got=%0b exp=1", issue_en); end
        n_checks++; if (issue_pld.pc !== 32'hE2) begin n_fail++; $display("FAIL age_first_pc got=%h exp=e2", issue_pld.pc); end
        n_checks++; if (issue_pld.reg_rs1_val !== 32'h42) begin n_fail++; $display("FAIL age_first_rs1 got=%h exp=42", issue_pld.reg_rs1_val); end
        step();
        $display("issue en=%0b pc=%h rs1=%h", issue_en, issue_pld.pc, issue_pld.reg_rs1_val);
        n_checks++; if (issue_pld.pc !== 32'hE3 || issue_en !== 1'b1) begin n_fail++; $display("FAIL age_second got=%0b/%h exp=1/e3", issue_en, issue_pld.pc); end
        n_checks++; if (issue_pld.reg_rs1_val !== 32'h43) begin n_fail++; $display("FAIL age_second_rs1 got=%h exp=43", issue_pld.reg_rs1_val); end
        flush = 1'b1;
        step();
        idle();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) begin
            dispatch(32'h50 + 32'(i), 1'b0, 6'(50 + i), 32'hBAD, 1'b1, 6'd1, 32'd0);
            step();
        end
        idle();
        set_wb(0, 6'd50, 32'h5);
        step();
        idle();
        n_checks++; if (iq_empty !== 1'b0) begin n_fail++; $display("FAIL flush_pre_empty got=%0b exp=0", iq_empty); end
        // Entry 0 is being selected this cycle; flush must cancel it and
        // drop the concurrent dispatch.
        flush = 1'b1;
        dispatch(32'h5F, 1'b1, 6'd2, 32'd1, 1'b1, 6'd3, 32'd1);
        step();
        idle();
        n_checks++; if (issue_en !== 1'b0) begin n_fail++; $display("FAIL flush_en got=%0b exp=0", issue_en); end
        n_checks++; if (iq_empty !== 1'b1) begin n_fail++; $display("FAIL flush_empty got=%0b exp=1", iq_empty); end
        n_checks++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got=%0b exp=1", disp_ready); end
        set_wb(0, 6'd51, 32'd1);
        set_wb(1, 6'd52, 32'd2);
        for (int k = 0; k < 3; k++) begin
            step();
            idle();
            n_checks++; if (issue_en !== 1'b0) begin n_fail++; $display("FAIL flush_ghost_%0d got=%0b exp=0 pc=%h", k, issue_en, issue_pld.pc); end
        end
        dispatch(32'h60, 1'b1, 6'd4, 32'd3, 1'b1, 6'd5, 32'd4);
        step();
        idle();
        $display("issue en=%0b pc=%h", issue_en, issue_pld.pc);
        n_checks++; if (issue_en !== 1'b1 || issue_pld.pc !== 32'h60) begin n_fail++; $display("FAIL flush_after got=%0b/%h exp=1/60", issue_en, issue_pld.pc); end
        step();
    endtask

    initial begin
        rst          = 1'b1;
        disp_valid   = 1'b0;
        disp_pld     = '0;
        disp_rs1_idx = '0;
        disp_rs2_idx = '0;
        disp_rs1_rdy = 1'b0;
        disp_rs2_rdy = 1'b0;
        wb_en        = '0;
        wb_index     = '0;
        wb_data      = '0;
        flush        = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_issue();
        test_wakeup_order();
        test_dispatch_bypass();
        test_full();
        test_age_order();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
